// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU control sequencer.
package cpu_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_FETCH     = 3'd1;
  localparam state_t ST_DECODE    = 3'd2;
  localparam state_t ST_EXECUTE   = 3'd3;
  localparam state_t ST_WRITEBACK = 3'd4;
  localparam state_t ST_HALTED    = 3'd5;
  localparam state_t ST_FAULT     = 3'd6;

  localparam logic [2:0] HALT_OP_DEFAULT = 3'b111;

  localparam int unsigned OPC_MSB = 7;
  localparam int unsigned OPC_LSB = 5;

endpackage

// File: rtl/cpu_sequencer_timer.sv
// Loadable down-counter with terminal-count flag, used for fetch timeout and execute length.
module seq_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == '0);

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute/writeback control sequencer gating PC, IR and register-file writes.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [2:0]  HALT_OP       = HALT_OP_DEFAULT,
  parameter int unsigned FETCH_TIMEOUT = 8,
  parameter int unsigned EXEC_CYCLES   = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic             clear,
  input  logic [2:0]       opcode,
  input  logic             ctrl_reg_write,
  input  logic             imem_ack,
  output logic             imem_req,
  output logic             ir_load,
  output logic             pc_en,
  output logic             rf_we,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  localparam logic [7:0] FETCH_LOAD = 8'(FETCH_TIMEOUT - 1);
  localparam logic [3:0] EXEC_LOAD  = 4'(EXEC_CYCLES - 1);

  state_t           state_q, state_d;
  logic             single_q, single_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             fetch_tc, exec_tc;

  // Timers reload whenever outside their state, so each entry starts a fresh count.
  seq_timer #(.W(8)) u_fetch_timer (
    .clk      (clk),
    .rst_n    (rst),
    .load     (state_q != ST_FETCH),
    .en       ((state_q == ST_FETCH) && !imem_ack),
    .load_val (FETCH_LOAD),
    .tc       (fetch_tc)
  );

  seq_timer #(.W(4)) u_exec_timer (
    .clk      (clk),
    .rst_n    (rst),
    .load     (state_q != ST_EXECUTE),
    .en       (state_q == ST_EXECUTE),
    .load_val (EXEC_LOAD),
    .tc       (exec_tc)
  );

  always_comb begin
    state_d   = state_q;
    single_d  = single_q;
    retired_d = retired_q;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d  = ST_FETCH;
          single_d = 1'b0;
        end else if (step) begin
          state_d  = ST_FETCH;
          single_d = 1'b1;
        end
      end
      ST_FETCH: begin
        if (imem_ack)      state_d = ST_DECODE;
        else if (fetch_tc) state_d = ST_FAULT;
      end
      ST_DECODE:  state_d = (opcode == HALT_OP) ? ST_HALTED : ST_EXECUTE;
      ST_EXECUTE: if (exec_tc) state_d = ST_WRITEBACK;
      ST_WRITEBACK: begin
        if (retired_q != '1) retired_d = retired_q + CNT_W'(1);
        state_d = (single_q || !run) ? ST_IDLE : ST_FETCH;
      end
      ST_HALTED, ST_FAULT: if (clear) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      single_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      single_q  <= single_d;
      retired_q <= retired_d;
    end
  end

  assign imem_req = (state_q == ST_FETCH);
  assign ir_load  = (state_q == ST_FETCH) && imem_ack;
  assign pc_en    = (state_q == ST_WRITEBACK);
  assign rf_we    = (state_q == ST_WRITEBACK) && ctrl_reg_write;
  assign busy     = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                    (state_q == ST_EXECUTE) || (state_q == ST_WRITEBACK);
  assign halted   = (state_q == ST_HALTED);
  assign fault    = (state_q == ST_FAULT);
  assign state_o  = state_q;
  assign retired  = retired_q;

endmodule
